// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc -- multi-cycle parametrised ALU for the datapath EX stage.
//
// Single-cycle ops (logic, add/sub, compare, shifts) are registered one edge
// after an accepted start. MUL runs an iterative shift-add multiplier for
// `bits` edges behind a start/busy/done handshake. Result and flags hold
// between done pulses.
//
// Parameters
//   bits    operand/result width (>= 4)
//   MUL_EN  1: MUL op implemented; 0: MUL code behaves as an unknown select
//
// Ports
//   clk     in   1     rising-edge clock
//   rst     in   1     synchronous active-high reset
//   start   in   1     operation request, sampled only when idle
//   A       in   bits  operand A (signed)
//   B       in   bits  operand B (signed; unsigned shift amount for shifts)
//   select  in   4     op code
//   busy    out  1     high while MUL iterates
//   done    out  1     one-cycle pulse: C/flags were just updated
//   C       out  bits  result
//   Zero    out  1     C == 0
//   Neg     out  1     C MSB
//   Carry   out  1     ADD carry-out / SUB no-borrow; 0 otherwise
//   Ovf     out  1     ADD/SUB signed overflow; 0 otherwise
// -----------------------------------------------------------------------------
module alu_mc #(
  parameter int bits   = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [bits-1:0] A,
  input  logic [bits-1:0] B,
  input  logic [3:0]      select,
  output logic            busy,
  output logic            done,
  output logic [bits-1:0] C,
  output logic            Zero,
  output logic            Neg,
  output logic            Carry,
  output logic            Ovf
);

  localparam int CW = $clog2(bits + 1);
  localparam logic [bits-1:0] BITS_V = bits'(bits);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t                r_state;
  logic [bits-1:0]       r_acc;
  logic [bits-1:0]       r_mplier;
  logic [bits-1:0]       r_mcand;
  logic [CW-1:0]         r_cnt;

  logic [bits:0]         w_sum;
  logic [bits:0]         w_diff;
  logic signed [bits-1:0] w_sra;
  logic [bits-1:0]       w_res;
  logic                  w_carry;
  logic                  w_ovf;
  logic                  w_is_mul;
  logic [bits-1:0]       w_acc_next;

  // Single-cycle result path, evaluated from the live inputs in IDLE.
  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_sum   = {1'b0, A} + {1'b0, B};
    w_diff  = {1'b0, A} - {1'b0, B};
    // Kept in its own signed variable so the shift stays arithmetic; inside a
    // mixed-sign ternary it would silently become a logical shift.
    w_sra   = $signed(A) >>> B;
    w_res   = '1;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (select)
      OP_AND: w_res = A & B;
      OP_OR:  w_res = A | B;
      OP_XOR: w_res = A ^ B;
      OP_NOR: w_res = ~(A | B);
      OP_ADD: begin
        w_res   = w_sum[bits-1:0];
        w_carry = w_sum[bits];
        w_ovf   = (A[bits-1] == B[bits-1]) && (w_sum[bits-1] != A[bits-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[bits-1:0];
        w_carry = ~w_diff[bits];          // no borrow <=> A >= B unsigned
        w_ovf   = (A[bits-1] != B[bits-1]) && (w_diff[bits-1] != A[bits-1]);
      end
      OP_SLT: w_res = {{(bits-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL: w_res = (B >= BITS_V) ? '0 : (A << B);
      OP_SRL: w_res = (B >= BITS_V) ? '0 : (A >> B);
      OP_SRA: w_res = (B >= BITS_V) ? {bits{A[bits-1]}} : w_sra;
      default: w_res = '1;                // unknown code, and MUL when disabled
    endcase
  end

  assign w_is_mul   = MUL_EN && (select == OP_MUL);
  assign w_acc_next = r_acc + (r_mcand[0] ? r_mplier : '0);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the multiplier datapath is reset too; it is tiny and a clean
      // reset keeps simulation free of X in the accumulator.
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      C        <= '0;
      Zero     <= 1'b1;
      Neg      <= 1'b0;
      Carry    <= 1'b0;
      Ovf      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_is_mul) begin
              r_mplier <= A;
              r_mcand  <= B;
              r_acc    <= '0;
              r_cnt    <= CW'(bits);
              busy     <= 1'b1;
              r_state  <= ST_MUL;
            end else begin
              C     <= w_res;
              Zero  <= (w_res == '0);
              Neg   <= w_res[bits-1];
              Carry <= w_carry;
              Ovf   <= w_ovf;
              done  <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          r_acc    <= w_acc_next;
          r_mplier <= r_mplier << 1;
          r_mcand  <= r_mcand >> 1;
          r_cnt    <= r_cnt - CW'(1);
          // Last iteration: publish the accumulator including this step.
          if (r_cnt == CW'(1)) begin
            C       <= w_acc_next;
            Zero    <= (w_acc_next == '0);
            Neg     <= w_acc_next[bits-1];
            Carry   <= 1'b0;
            Ovf     <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
